// File: rtl/load_store_unit_if.sv
// Execute-stage request/response and word-addressed data-memory port of the LSU.
// LSU_TIMEOUT_EN adds bus_error; slave is the LSU view, master is the core plus memory.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        misaligned;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
`ifdef LSU_TIMEOUT_EN
  logic        bus_error;

  modport slave (
    input  req_valid, is_store, funct3, addr, wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, rdata, misaligned, busy,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata, bus_error
  );
  modport master (
    output req_valid, is_store, funct3, addr, wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, rdata, misaligned, busy,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata, bus_error
  );
`else
  modport slave (
    input  req_valid, is_store, funct3, addr, wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, rdata, misaligned, busy,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
  modport master (
    output req_valid, is_store, funct3, addr, wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, rdata, misaligned, busy,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
`endif
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store stage: one access in flight, resp_valid 1 cycle after ack (faults: 1 cycle after accept).
// req_ready only in IDLE so the core stalls on busy; LSU_TIMEOUT_EN bounds the ack wait and reports bus_error.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..65535");
  end

  state_t      state_q;
  logic        req_ready_q, busy_q, resp_valid_q, misaligned_q;
  logic        mem_req_q, mem_we_q, is_store_q;
  logic [31:0] rdata_q, mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_be_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
`ifdef LSU_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic        bus_error_q;
  logic [15:0] wait_cnt_q;
`endif

  logic        legal_d, misal_d, fault_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, ld_data_d;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    legal_d = 1'b0;
    misal_d = 1'b0;
    be_d    = 4'b0000;
    wdata_d = bus.wdata;
    case (bus.funct3)
      3'b000, 3'b001, 3'b010: legal_d = 1'b1;
      3'b100, 3'b101:         legal_d = !bus.is_store;
      default:                legal_d = 1'b0;
    endcase
    case (bus.funct3[1:0])
      2'b01:   misal_d = bus.addr[0];
      2'b10:   misal_d = |bus.addr[1:0];
      default: misal_d = 1'b0;
    endcase
    fault_d = !legal_d || misal_d;
    case (bus.funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << bus.addr[1:0];
        wdata_d = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << {bus.addr[1], 1'b0};
        wdata_d = {2{bus.wdata[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = bus.wdata;
      end
    endcase
    if (!bus.is_store) begin
      be_d    = 4'b0000;
      wdata_d = 32'h0;
    end
  end

  // Lane select uses the address captured at accept, not the live request bus.
  always_comb begin
    lane_b = bus.mem_rdata[{addr_lo_q, 3'b000} +: 8];
    lane_h = addr_lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data_d = {{24{lane_b[7]}}, lane_b};
      3'b001:  ld_data_d = {{16{lane_h[15]}}, lane_h};
      3'b100:  ld_data_d = {24'h0, lane_b};
      3'b101:  ld_data_d = {16'h0, lane_h};
      default: ld_data_d = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      rdata_q      <= 32'h0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= 32'h0;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b000;
      addr_lo_q    <= 2'b00;
`ifdef LSU_TIMEOUT_EN
      bus_error_q  <= 1'b0;
      wait_cnt_q   <= 16'h0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            is_store_q  <= bus.is_store;
            funct3_q    <= bus.funct3;
            addr_lo_q   <= bus.addr[1:0];
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (fault_d) begin
              state_q      <= DONE;
              resp_valid_q <= 1'b1;
              misaligned_q <= 1'b1;
              rdata_q      <= 32'h0;
            end else begin
              state_q     <= REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.is_store;
              mem_addr_q  <= {bus.addr[31:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
`ifdef LSU_TIMEOUT_EN
              wait_cnt_q  <= 16'h0;
`endif
            end
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            state_q      <= DONE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'b0000;
            resp_valid_q <= 1'b1;
            rdata_q      <= is_store_q ? 32'h0 : ld_data_d;
`ifdef LSU_TIMEOUT_EN
          end else if (wait_cnt_q == TO_LAST) begin
            state_q      <= DONE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'b0000;
            resp_valid_q <= 1'b1;
            bus_error_q  <= 1'b1;
            rdata_q      <= 32'h0;
          end else begin
            wait_cnt_q   <= wait_cnt_q + 16'd1;
`endif
          end
        end
        DONE: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          misaligned_q <= 1'b0;
          rdata_q      <= 32'h0;
          busy_q       <= 1'b0;
          req_ready_q  <= 1'b1;
`ifdef LSU_TIMEOUT_EN
          bus_error_q  <= 1'b0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.busy       = busy_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.rdata      = rdata_q;
  assign bus.misaligned = misaligned_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_wdata  = mem_wdata_q;
`ifdef LSU_TIMEOUT_EN
  assign bus.bus_error  = bus_error_q;
`endif

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly downstream of the ALU in the RISC-V core. It takes the ALU Result as the effective address for LB/LH/LW/LBU/LHU/SB/SH/SW, plus rs2 as store data. It drives a word-addressed data-memory port with a req/ack handshake, aligns and extends load data, generates byte enables, and flags misaligned or illegal accesses. One access is in flight at a time, and the core stalls on busy.

Parameters:
TIMEOUT_CYCLES, 255, max cycles mem_req may wait for mem_ack (used only with LSU_TIMEOUT_EN); legal range 1..65535.

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  access request from execute stage
req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready
is_store  input  1  1 = store, 0 = load
funct3  input  3  RV32I width/sign field
addr  input  32  effective address (ALU Result)
wdata  input  32  store data (rs2)
resp_valid  output  1  one-cycle pulse: access complete
rdata  output  32  aligned and extended load data; 0 for stores and faults
misaligned  output  1  valid with resp_valid; access was misaligned or illegal, no memory access made
busy  output  1  high in REQ and DONE
mem_req  output  1  memory request
mem_we  output  1  write enable
mem_addr  output  32  {addr[31:2], 2'b00}
mem_be  output  4  byte enables (writes only; 4'b0000 on reads)
mem_wdata  output  32  lane-aligned store data
mem_ack  input  1  memory completion; mem_rdata valid in the same cycle
mem_rdata  input  32  read word

Behaviour:
- FSM states: IDLE, REQ, DONE. Reset state is IDLE. All outputs reset to 0, except req_ready = 1.
- IDLE:
  - On accept, register is_store, funct3, addr, and wdata.
  - Legal and aligned access -> REQ. Otherwise -> DONE with misaligned=1.
- Fault rules:
  - Legal load funct3: 000, 001, 010, 100, 101. Legal store funct3: 000, 001, 010. Any other value is illegal.
  - Halfword with addr[0]=1 is misaligned.
  - Word with addr[1:0]!=0 is misaligned.
- REQ:
  - mem_req=1. mem_addr, mem_we, mem_be, and mem_wdata are registered and held stable until mem_ack.
  - On mem_ack -> DONE. For loads, capture the extended data in the same edge.
- DONE:
  - resp_valid=1 for exactly one cycle, with rdata and misaligned valid.
  - Next state is IDLE. A new request can be accepted the cycle after DONE.
- Latency:
  - Accept at edge 0. mem_req is high from cycle 1. If ack arrives in cycle k, resp_valid is in cycle k+1.
  - Minimum 2 cycles from accept to resp_valid.
  - A fault gives resp_valid in cycle 1 and never asserts mem_req.
- Load data:
  - Select byte lane addr[1:0] or half addr[1].
  - LB/LH sign-extend bit 7/15. LBU/LHU zero-extend. LW passes the word through.
- Store data:
  - SB: mem_wdata = {4{wdata[7:0]}}, mem_be = 4'b0001 << addr[1:0].
  - SH: mem_wdata = {2{wdata[15:0]}}, mem_be = 4'b0011 << {addr[1],1'b0}.
  - SW: mem_wdata = wdata, mem_be = 4'b1111.
- Ignored inputs:
  - req_valid outside IDLE is ignored; req_ready=0 there.
  - mem_ack outside REQ is ignored.
- Reset mid-access: the FSM and all outputs clear asynchronously, mem_req drops immediately, and no resp_valid is produced for the aborted access.

Optional Feature:
LSU_TIMEOUT_EN:
- Defined:
  - Adds output bus_error (1 bit, reset 0, valid with resp_valid) and a 16-bit wait counter.
  - The counter clears on entry to REQ and increments each REQ cycle without mem_ack.
  - When the count reaches TIMEOUT_CYCLES without ack: drop mem_req, go to DONE with bus_error=1 and rdata=0.
  - An ack in the same cycle as the timeout wins, so the access completes normally.
- Undefined: no bus_error port and no counter; REQ waits indefinitely for mem_ack.

Test Plan:
- LW addr=0x100, mem_rdata=0xDEADBEEF, ack in 3rd REQ cycle -> mem_addr=0x100, mem_be=0, resp_valid 4 cycles after accept, rdata=0xDEADBEEF, misaligned=0.
- LB addr=0x203, mem_rdata=0x80FF1234 -> rdata=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU addr=0x202 -> 0x000080FF.
- SB addr=0x41, wdata=0x000000A5 -> mem_we=1, mem_be=4'b0010, mem_wdata=0xA5A5A5A5. SH addr=0x42, wdata=0x1234 -> mem_be=4'b1100, mem_wdata=0x12341234.
- LW addr=0x102, then SH addr=0x7, then load funct3=011 -> each gives resp_valid 1 cycle after accept, misaligned=1, mem_req never high.
- Assert rst during REQ with mem_req high -> mem_req=0 and req_ready=1 immediately; no resp_valid. A late mem_ack in IDLE is ignored.
- (LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4) LW with no ack -> mem_req high 4 cycles, then resp_valid with bus_error=1 and rdata=0. Ack on the 4th cycle -> normal completion, bus_error=0.
